bcd_display_scan: RTL and testbench
===================================

# bcd_display_scan

Time-multiplexed seven-segment display driver that consumes the 4-bit BCD outputs of the BCD counter stages, one digit per counter. It snapshots the digit vector, scans one digit at a time with a blanking gap between digits to suppress ghosting, and suppresses leading zeros. All outputs are registered and active-low, and drive common-anode display pins directly.

## Interface
Parameters:
- NUM_DIGITS, 4, number of BCD digits scanned (≥2); digit 0 is the least significant.
- REFRESH_DIV, 1000, clock cycles each digit is lit (≥1).
- BLANK_CYCLES, 2, clock cycles all anodes are off between digits (≥1).

Ports:
- clk  input  1  system clock; the block uses this one clock only.
- rst  input  1  reset, asynchronous and active-low: rst=0 resets immediately.
- digits_i  input  4*NUM_DIGITS  BCD digits; digit k occupies bits [4k+3:4k].
- load  input  1  single-cycle strobe that captures digits_i into the pending register.
- seg_o  output  7  segments {g,f,e,d,c,b,a}, active-low.
- an_o  output  NUM_DIGITS  digit enables, active-low, at most one low at a time.

## Operation
- Registers:
  - pending: captured from digits_i on any clock edge where load=1.
  - active: copied from pending at frame start (defined below). The display shows only active, so there is no tearing within a frame.
- FSM states:
  - GAP: an_o all 1; seg_o=7'h7F.
  - SHOW: an_o[idx]=0; seg_o=decode(active digit idx).
- Transitions:
  - GAP→SHOW after BLANK_CYCLES cycles in GAP.
  - SHOW→GAP after REFRESH_DIV cycles in SHOW.
  - idx increments on SHOW→GAP and wraps from NUM_DIGITS-1 to 0.
- Frame start is the GAP-entry cycle with idx=0, including the first GAP after reset. The pending→active copy happens on that edge.
- Decode patterns (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Invalid codes 10–15 show a dash, 3F.
  - Blank is 7F.
- Leading-zero blanking:
  - Digit k>0 shows blank if digit k and every higher digit are all 0.
  - Digit 0 is never blanked.
  - The anode is still driven low during a blanked digit's SHOW slot; only seg_o is blank.
  - An invalid digit counts as nonzero.
- Counters are sized with $clog2 of the maximum of REFRESH_DIV and BLANK_CYCLES. There is no overflow beyond the terminal count.

## Timing
- During reset (rst=0), asynchronously:
  - state=GAP, counter=0, idx=0, pending=0, active=0.
  - an_o all 1, seg_o=7'h7F.
- First SHOW cycle (digit 0) is edge BLANK_CYCLES after the first rising edge with rst=1. This edge is counted from the rst release.
- seg_o and an_o change on the same edge. Each SHOW slot lasts exactly REFRESH_DIV cycles, and each gap exactly BLANK_CYCLES cycles.
- Frame period = NUM_DIGITS*(REFRESH_DIV+BLANK_CYCLES) cycles.
- Load latency:
  - A load at cycle t updates pending at edge t.
  - That value becomes visible at the next frame start after t.
  - A load on the same edge as a frame start is not taken that frame; it appears one frame later.
- Back-to-back loads: last-wins into pending.
- Reset mid-scan: outputs go to reset values immediately. The scan restarts from GAP/idx 0, and pending and active are cleared.

## Structure
- Package bcd_disp_pkg contains:
  - state enum {GAP, SHOW};
  - localparam segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK.
- Sub-module bcd_to_7seg: combinational 4-bit→7-bit decoder, using the package constants.
- Top level contains the FSM, counters, pending/active registers, blanking logic and output registers.

## Test plan
All scenarios use a 10 ns clock with NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1.
- Reset, then release with load=0: an_o=4'hF and seg_o=7F during reset. After release, each frame shows digit 0 with an_o=4'hE and seg_o=40, and digits 1–3 have their anodes low with seg_o=7F (leading zeros blanked).
- load digits_i=16'h1234 mid-frame: the current frame is unchanged. The next frame shows an_o E/D/B/7 with seg_o 19/30/24/79, each slot 4 cycles, separated by 1-cycle gaps of an_o=F. The frame period is 20 cycles.
- load 16'h0A05: the digit 2 slot shows dash 3F and digit 1 shows 40 (not blanked, because an invalid digit counts as nonzero). Digit 3 is blank 7F, and digit 0 shows 12.
- load coinciding with the frame-start edge: the old value is shown for that frame and the new value from the following frame.
- Assert rst=0 mid-SHOW of digit 2: an_o=F and seg_o=7F immediately, without waiting for a clock edge. After release, the scan restarts at digit 0 after 1 gap cycle and shows 0 (pending and active cleared).

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// Shared types and active-low segment patterns for the multiplexed BCD display driver.
// Segment bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
package bcd_disp_pkg;

  typedef enum logic [0:0] {
    GAP  = 1'b0,
    SHOW = 1'b1
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes show a dash.
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern.
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed common-anode display scanner with inter-digit blanking gaps,
// frame-synchronous digit snapshot and leading-zero suppression.
module bcd_display_scan
  import bcd_disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic                    load,
  output logic [6:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   an_o
);

  localparam int MAX_CNT = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int IW      = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] BLANK_LAST   = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_DIGITS - 1);

  state_t                  state_r, state_nxt_s;
  logic [CW-1:0]           cnt_r, cnt_nxt_s;
  logic [IW-1:0]           idx_r, idx_nxt_s;
  logic                    frame_start_s;
  logic [4*NUM_DIGITS-1:0] pending_r, active_r;
  logic [NUM_DIGITS-1:0]   lead_blank_s;
  logic [3:0]              digit_sel_s;
  logic                    blank_sel_s;
  logic [6:0]              dec_seg_s, seg_nxt_s;
  logic [NUM_DIGITS-1:0]   an_nxt_s;
  logic                    zero_run_s;

  // Scan sequencing: gap/show dwell counters and digit index advance.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    idx_nxt_s     = idx_r;
    frame_start_s = 1'b0;
    case (state_r)
      GAP: begin
        if (cnt_r == BLANK_LAST) begin
          state_nxt_s = SHOW;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s = cnt_r + CW'(1);
        end
      end
      SHOW: begin
        if (cnt_r == REFRESH_LAST) begin
          state_nxt_s = GAP;
          cnt_nxt_s   = '0;
          if (idx_r == IDX_LAST) begin
            idx_nxt_s     = '0;
            frame_start_s = 1'b1;
          end else begin
            idx_nxt_s = idx_r + IW'(1);
          end
        end else begin
          cnt_nxt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_nxt_s = GAP;
        cnt_nxt_s   = '0;
        idx_nxt_s   = '0;
      end
    endcase
  end

  // A digit is suppressed when it and every more significant digit are zero; digit 0 never is.
  always_comb begin
    zero_run_s   = 1'b1;
    lead_blank_s = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run_s      = zero_run_s & (active_r[4*k +: 4] == 4'd0);
      lead_blank_s[k] = zero_run_s;
    end
  end

  // Select the digit about to be shown and build the next output pattern.
  always_comb begin
    digit_sel_s = 4'd0;
    blank_sel_s = 1'b0;
    an_nxt_s    = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_nxt_s == IW'(k)) begin
        digit_sel_s = active_r[4*k +: 4];
        blank_sel_s = lead_blank_s[k];
        an_nxt_s[k] = (state_nxt_s == SHOW) ? 1'b0 : 1'b1;
      end else begin
        an_nxt_s[k] = 1'b1;
      end
    end
    if ((state_nxt_s == SHOW) && !blank_sel_s) begin
      seg_nxt_s = dec_seg_s;
    end else begin
      seg_nxt_s = SEG_BLANK;
    end
  end

  bcd_to_7seg u_dec (
    .bcd (digit_sel_s),
    .seg (dec_seg_s)
  );

  // State, snapshot registers and registered display outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= GAP;
      cnt_r     <= '0;
      idx_r     <= '0;
      pending_r <= '0;
      active_r  <= '0;
      seg_o     <= SEG_BLANK;
      an_o      <= '1;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      idx_r     <= idx_nxt_s;
      pending_r <= load ? digits_i : pending_r;
      active_r  <= frame_start_s ? pending_r : active_r;
      seg_o     <= seg_nxt_s;
      an_o      <= an_nxt_s;
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan: expected per-cycle anode/segment values are
// queued by edge number and a negedge monitor pops and compares them.
module tb_bcd_display_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_i = 16'h0000;
  logic [6:0]  seg_o;
  logic [3:0]  an_o;

  int checks = 0;
  int failures = 0;
  int ecnt = 0;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t q[$];

  bcd_display_scan #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .digits_i (digits_i),
    .load     (load),
    .seg_o    (seg_o),
    .an_o     (an_o)
  );

  always #5 clk = ~clk;

  // Edge number since reset release; edge 1 is the first rising edge with rst=1.
  always @(posedge clk or negedge rst) begin
    if (!rst) ecnt <= 0;
    else      ecnt <= ecnt + 1;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare outputs for the edge at the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      while (q.size() > 0 && q[0].cyc < ecnt) begin
        e = q.pop_front();
        check($sformatf("missed_edge_%0d", e.cyc), 16'(ecnt), 16'(e.cyc));
      end
      if (q.size() > 0 && q[0].cyc == ecnt) begin
        e = q.pop_front();
        check($sformatf("an_edge_%0d", e.cyc), {12'h000, an_o}, {12'h000, e.an});
        check($sformatf("seg_edge_%0d", e.cyc), {9'h000, seg_o}, {9'h000, e.seg});
      end
    end
  end

  // Queue one frame starting after edge base: four 4-cycle slots each followed by a 1-cycle gap.
  task automatic push_frame(input int base, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3, input int last);
    logic [6:0] s [4];
    exp_t       e;
    s = '{s0, s1, s2, s3};
    for (int d = 0; d < 4; d++) begin
      for (int c = 1; c <= 5; c++) begin
        e.cyc = base + 5*d + c;
        e.an  = (c == 5) ? 4'hF : 4'(~(4'b0001 << d));
        e.seg = (c == 5) ? 7'h7F : s[d];
        if (e.cyc <= last) q.push_back(e);
      end
    end
  endtask

  task automatic wait_edge(input int n);
    int g = 0;
    while (ecnt != n && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (ecnt != n) begin
      checks++;
      failures++;
      $display("FAIL timeout_edge_%0d: got %0d expected %0d", n, ecnt, n);
    end
  endtask

  // Present a value so that it is captured on edge e.
  task automatic do_load(input int e, input logic [15:0] v);
    wait_edge(e - 1);
    digits_i = v;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
    digits_i = 16'h0000;
  endtask

  initial begin
    #12;
    check("reset_an", {12'h000, an_o}, 16'h000F);
    check("reset_seg", {9'h000, seg_o}, 16'h007F);
    @(negedge clk);
    rst = 1'b1;
    push_frame(0,   7'h40, 7'h7F, 7'h7F, 7'h7F, 1000);
    push_frame(20,  7'h19, 7'h30, 7'h24, 7'h79, 1000);
    push_frame(40,  7'h12, 7'h40, 7'h3F, 7'h7F, 1000);
    push_frame(60,  7'h12, 7'h40, 7'h3F, 7'h7F, 1000);
    push_frame(80,  7'h78, 7'h00, 7'h10, 7'h7F, 1000);
    push_frame(100, 7'h02, 7'h7F, 7'h7F, 7'h7F, 1000);
    push_frame(120, 7'h02, 7'h7F, 7'h7F, 7'h7F, 132);

    do_load(8,  16'h1234);
    do_load(30, 16'h0A05);
    do_load(60, 16'h0987);
    do_load(85, 16'h5555);
    do_load(86, 16'h0006);

    // Reset in the middle of digit 2's slot, between clock edges.
    wait_edge(132);
    #2;
    rst = 1'b0;
    #1;
    check("midscan_reset_an", {12'h000, an_o}, 16'h000F);
    check("midscan_reset_seg", {9'h000, seg_o}, 16'h007F);
    check("queue_drained_run1", 16'(q.size()), 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    push_frame(0,  7'h40, 7'h7F, 7'h7F, 7'h7F, 1000);
    push_frame(20, 7'h40, 7'h7F, 7'h7F, 7'h7F, 1000);
    wait_edge(41);
    check("queue_drained_run2", 16'(q.size()), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
